// File: rtl/cpu_host_loader.sv
// Host-side loader for the CPU's address/data pulse protocol: streams a program
// image into CPU RAM, optionally starts execution, then feeds runtime input bytes.
module cpu_host_loader #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_base_addr,
  input  logic [8:0] i_length,
  input  logic       i_run,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic [7:0] i_byte,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_busy,
  output logic       o_running,
  output logic       o_done,
  output logic       o_cpu_load_addr,
  output logic       o_cpu_load_data,
  output logic       o_cpu_execute,
  output logic       o_cpu_input_taken,
  output logic [7:0] o_cpu_data,
  input  logic       i_cpu_waiting,
  input  logic       i_cpu_take_input
);

  localparam int CW = $clog2(PULSE_CYCLES + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_A_WAIT, S_A_PULSE, S_A_REL, S_D_FETCH, S_D_PULSE, S_D_REL, S_NEXT,
    S_X_WAIT, S_X_PULSE, S_X_REL, S_RUN, S_IN_FETCH, S_IN_PULSE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [8:0]    remaining_q, remaining_d;
  logic          run_q, run_d;
  logic [7:0]    byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       load_addr_q, load_addr_d;
  logic       load_data_q, load_data_d;
  logic       execute_q, execute_d;
  logic       taken_q, taken_d;
  logic [7:0] cpu_data_q, cpu_data_d;
  logic       byte_ready_q, byte_ready_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       running_q, running_d;
  logic       done_q, done_d;

  logic addr_idle, data_phase, input_req;

  assign addr_idle  = i_cpu_waiting & ~i_cpu_take_input;
  assign data_phase = i_cpu_take_input & ~i_cpu_waiting;
  assign input_req  = i_cpu_waiting & i_cpu_take_input;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    run_d       = run_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d      = i_base_addr;
          remaining_d = i_length;
          run_d       = i_run;
          if (i_length != 9'd0) state_d = S_A_WAIT;
          else if (i_run)       state_d = S_X_WAIT;
          else                  done_d  = 1'b1;
        end
      end
      S_A_WAIT: begin
        if (addr_idle) begin
          state_d = S_A_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end
      end
      S_A_PULSE: begin
        if (cnt_q == '0) state_d = S_A_REL;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_A_REL: begin
        if (data_phase) state_d = S_D_FETCH;
      end
      S_D_FETCH: begin
        if (i_byte_valid && byte_ready_q) begin
          byte_d  = i_byte;
          state_d = S_D_PULSE;
          // one extra leading cycle so the byte is on the bus before load_data rises
          cnt_d   = CW'(PULSE_CYCLES);
        end
      end
      S_D_PULSE: begin
        if (cnt_q == '0) state_d = S_D_REL;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_D_REL: begin
        if (addr_idle) state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d      = addr_q + 8'd1;
        remaining_d = remaining_q - 9'd1;
        if (remaining_q != 9'd1) state_d = S_A_WAIT;
        else if (run_q)          state_d = S_X_WAIT;
        else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_X_WAIT: begin
        if (addr_idle) begin
          state_d = S_X_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end
      end
      S_X_PULSE: begin
        if (cnt_q == '0) state_d = S_X_REL;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_X_REL: begin
        if (!i_cpu_waiting) state_d = S_RUN;
      end
      S_RUN: begin
        if (input_req) state_d = S_IN_FETCH;
        else if (addr_idle) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_IN_FETCH: begin
        if (i_in_valid && in_ready_q) begin
          byte_d  = i_in_data;
          state_d = S_IN_PULSE;
          cnt_d   = CW'(1);
        end
      end
      S_IN_PULSE: begin
        // cnt_q != 0 marks the data setup cycle ahead of input_taken
        if (cnt_q != '0)         cnt_d   = '0;
        else if (!i_cpu_waiting) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are registered from next-state values so they line up with state_q
  always_comb begin
    cpu_data_d = 8'h00;
    case (state_d)
      S_A_WAIT, S_A_PULSE:               cpu_data_d = addr_d;
      S_D_PULSE, S_D_REL, S_IN_PULSE:    cpu_data_d = byte_d;
      default:                           cpu_data_d = 8'h00;
    endcase
    load_addr_d  = (state_d == S_A_PULSE);
    load_data_d  = (state_d == S_D_PULSE) && (cnt_d < CW'(PULSE_CYCLES));
    execute_d    = (state_d == S_X_PULSE);
    taken_d      = (state_d == S_IN_PULSE) && (cnt_d == '0);
    byte_ready_d = (state_d == S_D_FETCH);
    in_ready_d   = (state_d == S_IN_FETCH);
    busy_d       = (state_d != S_IDLE);
    running_d    = (state_d == S_X_REL) || (state_d == S_RUN) ||
                   (state_d == S_IN_FETCH) || (state_d == S_IN_PULSE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      run_q        <= 1'b0;
      byte_q       <= '0;
      cnt_q        <= '0;
      load_addr_q  <= 1'b0;
      load_data_q  <= 1'b0;
      execute_q    <= 1'b0;
      taken_q      <= 1'b0;
      cpu_data_q   <= '0;
      byte_ready_q <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      run_q        <= run_d;
      byte_q       <= byte_d;
      cnt_q        <= cnt_d;
      load_addr_q  <= load_addr_d;
      load_data_q  <= load_data_d;
      execute_q    <= execute_d;
      taken_q      <= taken_d;
      cpu_data_q   <= cpu_data_d;
      byte_ready_q <= byte_ready_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign o_cpu_load_addr   = load_addr_q;
  assign o_cpu_load_data   = load_data_q;
  assign o_cpu_execute     = execute_q;
  assign o_cpu_input_taken = taken_q;
  assign o_cpu_data        = cpu_data_q;
  assign o_byte_ready      = byte_ready_q;
  assign o_in_ready        = in_ready_q;
  assign o_busy            = busy_q;
  assign o_running         = running_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed bench for cpu_host_loader against a small behavioural CPU responder
// that writes its RAM from the pulse protocol and checks strobe/data timing.
module tb_cpu_host_loader;
  localparam int P = 2;

  logic       i_clk, i_reset, i_start, i_run;
  logic [7:0] i_base_addr, i_byte, i_in_data;
  logic [8:0] i_length;
  logic       i_byte_valid, i_in_valid;
  logic       o_byte_ready, o_in_ready, o_busy, o_running, o_done;
  logic       o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken;
  logic [7:0] o_cpu_data;
  logic       i_cpu_waiting, i_cpu_take_input;

  cpu_host_loader #(.PULSE_CYCLES(P)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .i_run(i_run), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .i_byte(i_byte), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_in_data(i_in_data), .o_busy(o_busy),
    .o_running(o_running), .o_done(o_done), .o_cpu_load_addr(o_cpu_load_addr),
    .o_cpu_load_data(o_cpu_load_data), .o_cpu_execute(o_cpu_execute),
    .o_cpu_input_taken(o_cpu_input_taken), .o_cpu_data(o_cpu_data),
    .i_cpu_waiting(i_cpu_waiting), .i_cpu_take_input(i_cpu_take_input)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- behavioural CPU responder ----------------
  typedef enum int {M_IDLE, M_A, M_D, M_DW, M_X, M_RUN, M_REQ, M_ACK} mst_t;
  mst_t       mst;
  logic [7:0] ram [256];
  logic [7:0] m_addr;
  logic [7:0] in_addr = 8'h20;
  int         inputs_target = 0;
  int n_la = 0, n_ld = 0, n_ex = 0, n_it = 0, n_done = 0, viol = 0;
  int w_la = 0, w_ld = 0, w_ex = 0;
  logic       p_it = 1'b0;
  logic [7:0] prev_data = 8'h00;

  assign i_cpu_waiting    = (mst == M_IDLE) || (mst == M_REQ);
  assign i_cpu_take_input = (mst == M_D) || (mst == M_REQ);

  always @(posedge i_clk) begin
    if (i_reset) begin
      mst <= M_IDLE;
      w_la = 0; w_ld = 0; w_ex = 0; p_it = 1'b0; prev_data = 8'h00;
    end else begin
      if (int'(o_cpu_load_addr) + int'(o_cpu_load_data) + int'(o_cpu_execute) +
          int'(o_cpu_input_taken) > 1) viol++;
      if ((o_cpu_load_addr | o_cpu_load_data | o_cpu_execute | o_cpu_input_taken) &&
          o_cpu_data !== prev_data) viol++;
      if (o_cpu_load_addr) begin if (w_la == 0) n_la++; w_la++; end
      else if (w_la != 0) begin if (w_la != P) viol++; w_la = 0; end
      if (o_cpu_load_data) begin if (w_ld == 0) n_ld++; w_ld++; end
      else if (w_ld != 0) begin if (w_ld != P) viol++; w_ld = 0; end
      if (o_cpu_execute) begin if (w_ex == 0) n_ex++; w_ex++; end
      else if (w_ex != 0) begin if (w_ex != P) viol++; w_ex = 0; end
      if (o_cpu_input_taken && !p_it) n_it++;
      p_it = o_cpu_input_taken;
      if (o_done) n_done++;
      prev_data = o_cpu_data;
      case (mst)
        M_IDLE: begin
          if (o_cpu_load_addr) begin m_addr <= o_cpu_data; mst <= M_A; end
          else if (o_cpu_execute) mst <= M_X;
          else if (o_cpu_load_data || o_cpu_input_taken) viol++;
        end
        M_A:   if (!o_cpu_load_addr) mst <= M_D;
        M_D:   if (o_cpu_load_data) begin ram[m_addr] <= o_cpu_data; mst <= M_DW; end
        M_DW:  if (!o_cpu_load_data) mst <= M_IDLE;
        M_X:   if (!o_cpu_execute) mst <= M_RUN;
        M_RUN: mst <= (n_it < inputs_target) ? M_REQ : M_IDLE;
        M_REQ: if (o_cpu_input_taken) begin ram[in_addr] <= o_cpu_data; mst <= M_ACK; end
        M_ACK: if (!o_cpu_input_taken) mst <= M_RUN;
        default: mst <= M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus driver ----------------
  logic [7:0] prog [$];
  logic [7:0] inq [$];

  task automatic run_job(input logic [7:0] base, input logic [8:0] len, input logic run,
                         input int gap, input bit mid_start,
                         output bit done_seen, output int cyc, output bit saw_running);
    int idx = 0, gcnt = 0, iidx = 0;
    done_seen = 1'b0; cyc = 0; saw_running = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1; i_base_addr = base; i_length = len; i_run = run;
    @(negedge i_clk);
    i_start = 1'b0;
    while (!done_seen && cyc < 5000) begin
      if (o_done) done_seen = 1'b1;
      else begin
        if (o_running) saw_running = 1'b1;
        if (gcnt > 0) begin i_byte_valid = 1'b0; gcnt--; end
        else if (idx < prog.size()) begin
          i_byte_valid = 1'b1; i_byte = prog[idx];
          if (o_byte_ready) begin idx++; gcnt = gap; end
        end else i_byte_valid = 1'b0;
        if (iidx < inq.size()) begin
          i_in_valid = 1'b1; i_in_data = inq[iidx];
          if (o_in_ready) iidx++;
        end else i_in_valid = 1'b0;
        if (mid_start && cyc == 20) begin
          i_start = 1'b1; i_base_addr = 8'h80; i_length = 9'd1; i_run = 1'b1;
        end else i_start = 1'b0;
        @(negedge i_clk);
        cyc++;
      end
    end
    i_byte_valid = 1'b0; i_in_valid = 1'b0; i_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_cpu_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 00", o_cpu_data); end
    n_checks++;
    if ({o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000",
        {o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken});
    end
    n_checks++;
    if ({o_byte_ready, o_in_ready, o_busy, o_running, o_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_status: got %b want 00000",
        {o_byte_ready, o_in_ready, o_busy, o_running, o_done});
    end
  endtask

  task automatic test_basic_load();
    bit d, r; int c; int la0 = n_la, ld0 = n_ld, ex0 = n_ex, dn0 = n_done, v0 = viol;
    prog = '{8'h05, 8'h06, 8'h07}; inq = '{};
    run_job(8'h10, 9'd3, 1'b0, 0, 1'b0, d, c, r);
    @(negedge i_clk);
    n_checks++;
    if (!d) begin n_fail++; $display("FAIL basic_done: timeout after %0d cycles", c); end
    n_checks++;
    if ({ram[8'h10], ram[8'h11], ram[8'h12]} !== 24'h050607) begin
      n_fail++; $display("FAIL basic_ram: got %h%h%h want 050607", ram[8'h10], ram[8'h11], ram[8'h12]);
    end
    n_checks++;
    if ((n_la - la0) != 3 || (n_ld - ld0) != 3 || (n_ex - ex0) != 0) begin
      n_fail++; $display("FAIL basic_pulses: la %0d ld %0d ex %0d want 3 3 0", n_la - la0, n_ld - ld0, n_ex - ex0);
    end
    n_checks++;
    if ((n_done - dn0) != 1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_count: done %0d busy %b want 1 0", n_done - dn0, o_busy);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL basic_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_wrap();
    bit d, r; int c; int v0 = viol;
    prog = '{8'h11, 8'h22, 8'h33}; inq = '{};
    run_job(8'hFE, 9'd3, 1'b0, 0, 1'b0, d, c, r);
    n_checks++;
    if (!d || {ram[8'hFE], ram[8'hFF], ram[8'h00]} !== 24'h112233) begin
      n_fail++; $display("FAIL wrap_ram: done %b got %h%h%h want 112233", d, ram[8'hFE], ram[8'hFF], ram[8'h00]);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL wrap_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_zero_length();
    bit d, r; int c; int la0 = n_la, ld0 = n_ld, ex0 = n_ex;
    prog = '{}; inq = '{};
    inputs_target = n_it;
    run_job(8'h00, 9'd0, 1'b0, 0, 1'b0, d, c, r);
    n_checks++;
    if (!d || c != 0) begin n_fail++; $display("FAIL zero_done_latency: done %b after %0d extra cycles want 1 0", d, c); end
    n_checks++;
    if (n_la != la0 || n_ld != ld0 || n_ex != ex0) begin
      n_fail++; $display("FAIL zero_no_strobes: la %0d ld %0d ex %0d want 0", n_la - la0, n_ld - ld0, n_ex - ex0);
    end
    run_job(8'h00, 9'd0, 1'b1, 0, 1'b0, d, c, r);
    n_checks++;
    if (!d || (n_ex - ex0) != 1 || n_la != la0 || n_ld != ld0) begin
      n_fail++; $display("FAIL zero_run_exec: done %b ex %0d la %0d ld %0d want 1 1 0 0",
        d, n_ex - ex0, n_la - la0, n_ld - ld0);
    end
  endtask

  task automatic test_run_input();
    bit d, r; int c; int it0 = n_it, ex0 = n_ex, v0 = viol;
    prog = '{8'hC1, 8'h20, 8'h00}; inq = '{8'hA5};
    in_addr = 8'h20;
    inputs_target = n_it + 1;
    run_job(8'h00, 9'd3, 1'b1, 0, 1'b0, d, c, r);
    @(negedge i_clk);
    n_checks++;
    if (!d || ram[8'h20] !== 8'hA5) begin n_fail++; $display("FAIL run_ram: done %b got %h want A5", d, ram[8'h20]); end
    n_checks++;
    if ((n_it - it0) != 1 || (n_ex - ex0) != 1) begin
      n_fail++; $display("FAIL run_pulses: taken %0d exec %0d want 1 1", n_it - it0, n_ex - ex0);
    end
    n_checks++;
    if (!r || o_running !== 1'b0) begin
      n_fail++; $display("FAIL run_running: seen %b end %b want 1 0", r, o_running);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL run_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_gaps_and_mid_start();
    bit d, r; int c; int la0 = n_la, dn0 = n_done, ex0 = n_ex;
    prog = '{8'hD0, 8'hD1, 8'hD2, 8'hD3}; inq = '{};
    run_job(8'h50, 9'd4, 1'b0, 5, 1'b1, d, c, r);
    repeat (10) @(negedge i_clk);
    n_checks++;
    if (!d || {ram[8'h50], ram[8'h51], ram[8'h52], ram[8'h53]} !== 32'hD0D1D2D3) begin
      n_fail++; $display("FAIL gap_ram: done %b got %h%h%h%h want D0D1D2D3",
        d, ram[8'h50], ram[8'h51], ram[8'h52], ram[8'h53]);
    end
    n_checks++;
    if ((n_la - la0) != 4 || (n_done - dn0) != 1 || n_ex != ex0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL gap_mid_start: la %0d done %0d ex %0d busy %b want 4 1 0 0",
        n_la - la0, n_done - dn0, n_ex - ex0, o_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    bit d, r; int c, k; int dn0;
    @(negedge i_clk);
    i_start = 1'b1; i_base_addr = 8'h60; i_length = 9'd2; i_run = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0; i_byte_valid = 1'b1; i_byte = 8'h33;
    k = 0;
    while (!o_cpu_load_data && k < 200) begin @(negedge i_clk); k++; end
    n_checks++;
    if (!o_cpu_load_data) begin n_fail++; $display("FAIL rst_reach_dpulse: load_data %b want 1", o_cpu_load_data); end
    dn0 = n_done;
    i_reset = 1'b1; i_byte_valid = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if ({o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken, o_byte_ready,
         o_in_ready, o_busy, o_running, o_done} !== 9'b0 || o_cpu_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_outputs: got %b data %h want 0",
        {o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken, o_byte_ready,
         o_in_ready, o_busy, o_running, o_done}, o_cpu_data);
    end
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (n_done != dn0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_done: done %0d busy %b want 0 0", n_done - dn0, o_busy);
    end
    prog = '{8'h9A, 8'h9B}; inq = '{};
    run_job(8'h40, 9'd2, 1'b0, 0, 1'b0, d, c, r);
    n_checks++;
    if (!d || {ram[8'h40], ram[8'h41]} !== 16'h9A9B) begin
      n_fail++; $display("FAIL rst_fresh_load: done %b got %h%h want 9A9B", d, ram[8'h40], ram[8'h41]);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_length = '0; i_run = 1'b0;
    i_byte_valid = 1'b0; i_byte = '0; i_in_valid = 1'b0; i_in_data = '0;
    test_reset();
    test_basic_load();
    test_wrap();
    test_zero_length();
    test_run_input();
    test_gaps_and_mid_start();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_host_loader.md
# cpu_host_loader

Host-side driver for the CPU's loader/input handshake. It streams a program image into CPU RAM through the address/data pulse protocol, optionally starts execution, then services the CPU's runtime input requests from a byte stream until the CPU halts. It is the initiator for the CPU's responder, and sits between a byte source (UART, ROM reader, testbench) and the `cpu` top level in the same clock domain.

## Interface
- PULSE_CYCLES, 2: cycles each CPU strobe (load_addr, load_data, execute) is held high; ≥1.
- i_clk  in  1  clock (same domain as CPU)
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk
- i_start  in  1  one-cycle request to begin a load; ignored while o_busy
- i_base_addr  in  8  first RAM address, sampled on i_start
- i_length  in  9  byte count 0..256, sampled on i_start
- i_run  in  1  sampled on i_start; 1 = execute after load and service input until halt
- i_byte_valid / o_byte_ready  in/out  1  program byte stream handshake
- i_byte  in  8  program byte
- i_in_valid / o_in_ready  in/out  1  runtime input stream handshake
- i_in_data  in  8  runtime input byte
- o_busy  out  1  high from accepted i_start until return to IDLE
- o_running  out  1  high while the CPU executes (EXEC_REL through RUN/IN_*)
- o_done  out  1  one-cycle pulse on return to IDLE
- o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken  out  1  CPU strobes
- o_cpu_data  out  8  CPU i_data_in bus
- i_cpu_waiting, i_cpu_take_input  in  1  CPU o_waiting / o_take_input

## Operation
- CPU phases decoded: ADDR_IDLE = waiting & !take_input; DATA_PHASE = take_input & !waiting; INPUT_REQ = waiting & take_input.
- Byte transfers occur only when valid & ready are both high on the same edge.
- States: IDLE, A_WAIT, A_PULSE, A_REL, D_FETCH, D_PULSE, D_REL, NEXT, X_WAIT, X_PULSE, X_REL, RUN, IN_FETCH, IN_PULSE.
- IDLE: on i_start, latch addr/length/run. If length = 0, go to X_WAIT when run = 1, otherwise to IDLE with o_done.
- A_WAIT: drive o_cpu_data = addr. On ADDR_IDLE go to A_PULSE.
- A_PULSE: load_addr high for PULSE_CYCLES, data held at addr, then go to A_REL.
- A_REL: load_addr low. On DATA_PHASE go to D_FETCH.
- D_FETCH: o_byte_ready high. On transfer, capture the byte and go to D_PULSE. o_cpu_data = captured byte from D_FETCH exit through D_REL.
- D_PULSE: load_data high for PULSE_CYCLES, then go to D_REL.
- D_REL: on ADDR_IDLE go to NEXT.
- NEXT: addr = addr+1 mod 256 (wraps 0xFF→0x00); remaining−1. If remaining = 0: go to X_WAIT when run = 1, otherwise IDLE + o_done. Else go to A_WAIT.
- X_WAIT: o_cpu_data = 0. On ADDR_IDLE go to X_PULSE.
- X_PULSE: execute high for PULSE_CYCLES, then go to X_REL.
- X_REL: execute low. Once !i_cpu_waiting, go to RUN.
- RUN:
  - INPUT_REQ → IN_FETCH.
  - ADDR_IDLE (CPU halted) → IDLE + o_done.
- IN_FETCH: o_in_ready high. On transfer, capture the byte and go to IN_PULSE.
- IN_PULSE: o_cpu_data = captured byte; input_taken high until !i_cpu_waiting (held at least 1 cycle), then low, return to RUN.
- o_cpu_data = 0 whenever not specified above.
- At most one CPU strobe is high in any cycle.

## Timing
- Reset: state IDLE, every output 0 (o_cpu_data = 0x00, all strobes low, ready low, o_busy/o_running/o_done low), counters cleared. Reset mid-load aborts with no o_done; the CPU is reset by the same signal.
- Strobes are registered outputs, high exactly PULSE_CYCLES cycles.
- o_cpu_data is stable ≥1 cycle before any strobe rises and until it falls.
- Best-case byte cost with a stream always valid: 2·PULSE_CYCLES + 6 cycles.
- i_start while busy: no effect. i_byte_valid outside D_FETCH: not consumed, ready low.
- Stalls on the stream or the CPU are unbounded; no timeout.
- o_done asserts the cycle after the final transition; o_busy falls in the same cycle.

## Test plan
- Load base 0x10, length 3, bytes 0x05,0x06,0x07, run=0, against cpu → RAM[0x10..0x12] = 05,06,07; exactly 3 load_addr and 3 load_data pulses; one o_done; no execute.
- Base 0xFE, length 3 → writes to 0xFE, 0xFF, 0x00 (wrap).
- Length 0, run=0 → o_done one cycle after start, no strobes. Length 0, run=1 → single execute pulse only.
- Program WRIM 0x20; HALT with run=1, in stream 0xA5 → RAM[0x20] = 0xA5, one input_taken pulse, o_running falls, o_done.
- Program byte stream with valid gaps of 5 cycles, plus i_start pulsed mid-load → correct RAM contents, second start ignored.
- i_reset asserted in D_PULSE → next cycle all outputs 0, state IDLE, no o_done; a fresh load then succeeds.
